// File: rtl/directory_req_engine_pkg.sv
// Shared opcodes, MSI encodings and FSM states for the directory request engine.
// Agent ids at or above NUM_CACHES address the memory controller.
package directory_req_engine_pkg;

    localparam logic [2:0] OP_NOOP  = 3'd0;
    localparam logic [2:0] OP_REPLY = 3'd2;
    localparam logic [2:0] OP_RD    = 3'd3;
    localparam logic [2:0] OP_WR    = 3'd4;
    localparam logic [2:0] OP_INV   = 3'd5;
    localparam logic [2:0] OP_UPD   = 3'd6;
    localparam logic [2:0] OP_RWITM = 3'd7;

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DONE
    } dir_state_e;

    function automatic logic is_mem_id(input int id, input int num_caches);
        return id >= num_caches;
    endfunction

endpackage

// File: rtl/directory_req_engine_if.sv
// Request, queue-allocation, ack and response signals of the directory request engine.
// The engine uses the slave side; the requester/queue model uses the master side.
interface directory_req_engine_if #(
    parameter int NUM_CACHES = 2,
    parameter int SRC_W      = $clog2(NUM_CACHES + 1)
);
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_op;
    logic [SRC_W-1:0]        req_src;
    logic [SRC_W-1:0]        req_dest;
    logic [2*NUM_CACHES-1:0] req_state;
    logic [NUM_CACHES-1:0]   cache_inst_q_alloc;
    logic [3*NUM_CACHES-1:0] cache_inst_q_op;
    logic [NUM_CACHES-1:0]   cache_inst_q_full;
    logic [NUM_CACHES-1:0]   cache_data_q_alloc;
    logic [3*NUM_CACHES-1:0] cache_data_q_op;
    logic [NUM_CACHES-1:0]   cache_data_q_full;
    logic                    mem_inst_q_alloc;
    logic [2:0]              mem_inst_q_op;
    logic                    mem_inst_q_full;
    logic                    mem_data_q_alloc;
    logic [2:0]              mem_data_q_op;
    logic                    mem_data_q_full;
    logic [NUM_CACHES-1:0]   ack_valid;
    logic                    resp_valid;
    logic [2*NUM_CACHES-1:0] resp_next_state;
    logic                    err_timeout;
    logic                    err_spurious_ack;

    modport master (
        output req_valid, req_op, req_src, req_dest, req_state,
               cache_inst_q_full, cache_data_q_full, mem_inst_q_full, mem_data_q_full, ack_valid,
        input  req_ready, cache_inst_q_alloc, cache_inst_q_op, cache_data_q_alloc, cache_data_q_op,
               mem_inst_q_alloc, mem_inst_q_op, mem_data_q_alloc, mem_data_q_op,
               resp_valid, resp_next_state, err_timeout, err_spurious_ack
    );

    modport slave (
        input  req_valid, req_op, req_src, req_dest, req_state,
               cache_inst_q_full, cache_data_q_full, mem_inst_q_full, mem_data_q_full, ack_valid,
        output req_ready, cache_inst_q_alloc, cache_inst_q_op, cache_data_q_alloc, cache_data_q_op,
               mem_inst_q_alloc, mem_inst_q_op, mem_data_q_alloc, mem_data_q_op,
               resp_valid, resp_next_state, err_timeout, err_spurious_ack
    );

endinterface

// File: rtl/directory_req_engine_target_decode.sv
// Combinational decode of a latched coherence request into queue allocations,
// expected ack count and the next directory state vector.
module directory_req_engine_target_decode
    import directory_req_engine_pkg::*;
#(
    parameter int NUM_CACHES = 2,
    parameter int SRC_W      = $clog2(NUM_CACHES + 1),
    parameter int ACK_W      = $clog2(NUM_CACHES + 1)
) (
    input  logic [2:0]              op,
    input  logic [SRC_W-1:0]        src,
    input  logic [SRC_W-1:0]        dest,
    input  logic [2*NUM_CACHES-1:0] cur_state,
    output logic [NUM_CACHES-1:0]   inst_mask,
    output logic [3*NUM_CACHES-1:0] inst_op,
    output logic [NUM_CACHES-1:0]   data_mask,
    output logic [3*NUM_CACHES-1:0] data_op,
    output logic                    mem_inst,
    output logic [2:0]              mem_inst_op,
    output logic                    mem_data,
    output logic [2:0]              mem_data_op,
    output logic [ACK_W-1:0]        ack_count,
    output logic [2*NUM_CACHES-1:0] next_state
);

    logic                  src_mem;
    logic                  dest_mem;
    logic                  owner_found;
    logic [NUM_CACHES-1:0] owner_sel;

    // Lowest-numbered non-requesting cache holding the line in M owns it.
    always_comb begin
        src_mem     = is_mem_id(int'(src), NUM_CACHES);
        dest_mem    = is_mem_id(int'(dest), NUM_CACHES);
        owner_found = 1'b0;
        owner_sel   = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (!owner_found && src != SRC_W'(i) && cur_state[2*i +: 2] == MSI_M) begin
                owner_found  = 1'b1;
                owner_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        inst_mask   = '0;
        inst_op     = '0;
        data_mask   = '0;
        data_op     = '0;
        mem_inst    = 1'b0;
        mem_inst_op = OP_NOOP;
        mem_data    = 1'b0;
        mem_data_op = OP_NOOP;
        ack_count   = '0;
        next_state  = cur_state;
        case (op)
            OP_REPLY: begin
                if (dest_mem) begin
                    mem_data    = 1'b1;
                    mem_data_op = OP_WR;
                end else begin
                    for (int i = 0; i < NUM_CACHES; i++) begin
                        if (dest == SRC_W'(i)) begin
                            data_mask[i]      = 1'b1;
                            data_op[3*i +: 3] = OP_WR;
                        end
                    end
                end
            end
            OP_RD: begin
                if (!src_mem) begin
                    for (int i = 0; i < NUM_CACHES; i++) begin
                        if (owner_sel[i]) begin
                            inst_mask[i]         = 1'b1;
                            inst_op[3*i +: 3]    = OP_RD;
                            next_state[2*i +: 2] = MSI_S;
                        end
                        if (src == SRC_W'(i)) next_state[2*i +: 2] = MSI_S;
                    end
                    if (owner_found) begin
                        ack_count = ACK_W'(1);
                    end else begin
                        mem_inst    = 1'b1;
                        mem_inst_op = OP_RD;
                    end
                end
            end
            OP_RWITM: begin
                if (!src_mem) begin
                    for (int i = 0; i < NUM_CACHES; i++) begin
                        if (src == SRC_W'(i)) begin
                            next_state[2*i +: 2] = MSI_M;
                        end else begin
                            next_state[2*i +: 2] = MSI_I;
                            if (cur_state[2*i +: 2] != MSI_I) begin
                                inst_mask[i]      = 1'b1;
                                inst_op[3*i +: 3] = OP_INV;
                                ack_count         = ack_count + ACK_W'(1);
                            end
                        end
                    end
                    if (!owner_found) begin
                        mem_inst    = 1'b1;
                        mem_inst_op = OP_RD;
                    end
                end
            end
            OP_UPD: begin
                if (!src_mem) begin
                    for (int i = 0; i < NUM_CACHES; i++) begin
                        if (src == SRC_W'(i)) begin
                            inst_mask[i]         = 1'b1;
                            inst_op[3*i +: 3]    = OP_UPD;
                            next_state[2*i +: 2] = MSI_M;
                        end else begin
                            next_state[2*i +: 2] = MSI_I;
                            if (cur_state[2*i +: 2] == MSI_S) begin
                                inst_mask[i]      = 1'b1;
                                inst_op[3*i +: 3] = OP_INV;
                                ack_count         = ack_count + ACK_W'(1);
                            end
                        end
                    end
                end
            end
            OP_INV, OP_WR: begin
                for (int i = 0; i < NUM_CACHES; i++) begin
                    if (!src_mem && src == SRC_W'(i)) begin
                        if (cur_state[2*i +: 2] == MSI_M) begin
                            mem_data             = 1'b1;
                            mem_data_op          = OP_WR;
                            next_state[2*i +: 2] = (op == OP_WR) ? MSI_S : MSI_I;
                        end else if (op == OP_INV) begin
                            next_state[2*i +: 2] = MSI_I;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/directory_req_engine.sv
// Directory request engine: latches one request, issues all its queue allocations
// atomically under backpressure, collects acks with a timeout and reports the next state.
module directory_req_engine
    import directory_req_engine_pkg::*;
#(
    parameter int NUM_CACHES  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    directory_req_engine_if.slave bus
);

    localparam int SRC_W = $clog2(NUM_CACHES + 1);
    localparam int ACK_W = $clog2(NUM_CACHES + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    dir_state_e              state;
    logic [2:0]              op_q;
    logic [SRC_W-1:0]        src_q;
    logic [SRC_W-1:0]        dest_q;
    logic [2*NUM_CACHES-1:0] cur_state_q;
    logic [ACK_W-1:0]        ack_cnt;
    logic [ACK_W-1:0]        ack_pop;
    logic [TMO_W-1:0]        tmo_cnt;
    logic                    blocked;

    logic [NUM_CACHES-1:0]   dec_inst_mask;
    logic [3*NUM_CACHES-1:0] dec_inst_op;
    logic [NUM_CACHES-1:0]   dec_data_mask;
    logic [3*NUM_CACHES-1:0] dec_data_op;
    logic                    dec_mem_inst;
    logic [2:0]              dec_mem_inst_op;
    logic                    dec_mem_data;
    logic [2:0]              dec_mem_data_op;
    logic [ACK_W-1:0]        dec_ack_count;
    logic [2*NUM_CACHES-1:0] dec_next_state;

    directory_req_engine_target_decode #(
        .NUM_CACHES(NUM_CACHES),
        .SRC_W     (SRC_W),
        .ACK_W     (ACK_W)
    ) u_decode (
        .op         (op_q),
        .src        (src_q),
        .dest       (dest_q),
        .cur_state  (cur_state_q),
        .inst_mask  (dec_inst_mask),
        .inst_op    (dec_inst_op),
        .data_mask  (dec_data_mask),
        .data_op    (dec_data_op),
        .mem_inst   (dec_mem_inst),
        .mem_inst_op(dec_mem_inst_op),
        .mem_data   (dec_mem_data),
        .mem_data_op(dec_mem_data_op),
        .ack_count  (dec_ack_count),
        .next_state (dec_next_state)
    );

    assign bus.req_ready = (state == ST_IDLE) && !rst;

    // A single full queue among the targets stalls the whole issue.
    assign blocked = (|(dec_inst_mask & bus.cache_inst_q_full))
                   | (|(dec_data_mask & bus.cache_data_q_full))
                   | (dec_mem_inst & bus.mem_inst_q_full)
                   | (dec_mem_data & bus.mem_data_q_full);

    always_comb begin
        ack_pop = '0;
        for (int i = 0; i < NUM_CACHES; i++) begin
            if (bus.ack_valid[i]) ack_pop = ack_pop + ACK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            op_q                   <= OP_NOOP;
            src_q                  <= '0;
            dest_q                 <= '0;
            cur_state_q            <= '0;
            ack_cnt                <= '0;
            tmo_cnt                <= '0;
            bus.cache_inst_q_alloc <= '0;
            bus.cache_inst_q_op    <= '0;
            bus.cache_data_q_alloc <= '0;
            bus.cache_data_q_op    <= '0;
            bus.mem_inst_q_alloc   <= 1'b0;
            bus.mem_inst_q_op      <= '0;
            bus.mem_data_q_alloc   <= 1'b0;
            bus.mem_data_q_op      <= '0;
            bus.resp_valid         <= 1'b0;
            bus.resp_next_state    <= '0;
            bus.err_timeout        <= 1'b0;
            bus.err_spurious_ack   <= 1'b0;
        end else begin
            bus.cache_inst_q_alloc <= '0;
            bus.cache_inst_q_op    <= '0;
            bus.cache_data_q_alloc <= '0;
            bus.cache_data_q_op    <= '0;
            bus.mem_inst_q_alloc   <= 1'b0;
            bus.mem_inst_q_op      <= '0;
            bus.mem_data_q_alloc   <= 1'b0;
            bus.mem_data_q_op      <= '0;
            bus.resp_valid         <= 1'b0;
            bus.resp_next_state    <= '0;
            if (state != ST_WAIT_ACK && (|bus.ack_valid)) bus.err_spurious_ack <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        src_q       <= bus.req_src;
                        dest_q      <= bus.req_dest;
                        cur_state_q <= bus.req_state;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!blocked) begin
                        bus.cache_inst_q_alloc <= dec_inst_mask;
                        bus.cache_inst_q_op    <= dec_inst_op;
                        bus.cache_data_q_alloc <= dec_data_mask;
                        bus.cache_data_q_op    <= dec_data_op;
                        bus.mem_inst_q_alloc   <= dec_mem_inst;
                        bus.mem_inst_q_op      <= dec_mem_inst_op;
                        bus.mem_data_q_alloc   <= dec_mem_data;
                        bus.mem_data_q_op      <= dec_mem_data_op;
                        ack_cnt                <= dec_ack_count;
                        tmo_cnt                <= '0;
                        state                  <= (dec_ack_count == '0) ? ST_DONE : ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    // The final ack takes priority over a timeout landing on the same cycle.
                    if (ack_pop >= ack_cnt) begin
                        if (ack_pop > ack_cnt) bus.err_spurious_ack <= 1'b1;
                        ack_cnt <= '0;
                        state   <= ST_DONE;
                    end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                        bus.err_timeout <= 1'b1;
                        ack_cnt         <= '0;
                        state           <= ST_DONE;
                    end else begin
                        ack_cnt <= ack_cnt - ack_pop;
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.resp_valid      <= 1'b1;
                    bus.resp_next_state <= dec_next_state;
                    state               <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_directory_req_engine.sv
// Directed bench for directory_req_engine with four caches and an 8-cycle ack timeout.
module tb_directory_req_engine;

    localparam int NC     = 4;
    localparam int ACK_TO = 8;

    localparam logic [2:0] T_REPLY = 3'd2;
    localparam logic [2:0] T_RD    = 3'd3;
    localparam logic [2:0] T_WR    = 3'd4;
    localparam logic [2:0] T_UPD   = 3'd6;
    localparam logic [2:0] T_RWITM = 3'd7;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    directory_req_engine_if #(.NUM_CACHES(NC)) bus ();

    directory_req_engine #(
        .NUM_CACHES (NC),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle; returns just after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] src,
                                 input logic [2:0] dest, input logic [7:0] st);
        checkOutput("ready_before_req", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src   = src;
        bus.req_dest  = dest;
        bus.req_state = st;
        step();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        rst                   = 1'b1;
        bus.req_valid         = 1'b0;
        bus.req_op            = 3'd0;
        bus.req_src           = 3'd0;
        bus.req_dest          = 3'd0;
        bus.req_state         = 8'h00;
        bus.cache_inst_q_full = 4'b0000;
        bus.cache_data_q_full = 4'b0000;
        bus.mem_inst_q_full   = 1'b0;
        bus.mem_data_q_full   = 1'b0;
        bus.ack_valid         = 4'b0000;
        step();
        step();
        checkOutput("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("rst_resp", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_inst_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'd0);
        checkOutput("rst_mem_alloc", {31'd0, bus.mem_inst_q_alloc}, 32'd0);
        checkOutput("rst_errs", {30'd0, bus.err_timeout, bus.err_spurious_ack}, 32'd0);
        rst = 1'b0;
        #1;

        $display("[TB] RD, no owner: memory read, response two cycles after accept");
        applyStimulus(T_RD, 3'd0, 3'd0, 8'h00);
        checkOutput("rd_mem_busy", {31'd0, bus.req_ready}, 32'd0);
        step();
        checkOutput("rd_mem_alloc", {31'd0, bus.mem_inst_q_alloc}, 32'd1);
        checkOutput("rd_mem_op", {29'd0, bus.mem_inst_q_op}, 32'd3);
        checkOutput("rd_mem_cache_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'd0);
        checkOutput("rd_mem_resp_early", {31'd0, bus.resp_valid}, 32'd0);
        step();
        checkOutput("rd_mem_resp", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("rd_mem_state", {24'd0, bus.resp_next_state}, 32'h01);
        checkOutput("rd_mem_pulse", {31'd0, bus.mem_inst_q_alloc}, 32'd0);
        step();
        checkOutput("rd_mem_resp_pulse", {31'd0, bus.resp_valid}, 32'd0);

        $display("[TB] RD, cache1 owns in M: forward and one ack");
        applyStimulus(T_RD, 3'd0, 3'd0, 8'h08);
        step();
        checkOutput("rd_own_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'b0010);
        checkOutput("rd_own_op", {20'd0, bus.cache_inst_q_op}, 32'h018);
        checkOutput("rd_own_mem", {31'd0, bus.mem_inst_q_alloc}, 32'd0);
        step();
        step();
        checkOutput("rd_own_wait", {31'd0, bus.resp_valid}, 32'd0);
        bus.ack_valid = 4'b0010;
        step();
        bus.ack_valid = 4'b0000;
        checkOutput("rd_own_wait2", {31'd0, bus.resp_valid}, 32'd0);
        step();
        checkOutput("rd_own_resp", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("rd_own_state", {24'd0, bus.resp_next_state}, 32'h05);

        $display("[TB] RWITM, caches1..3 shared: three invalidates at once");
        applyStimulus(T_RWITM, 3'd0, 3'd0, 8'h54);
        step();
        checkOutput("rwitm_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'b1110);
        checkOutput("rwitm_op", {20'd0, bus.cache_inst_q_op}, 32'hB68);
        checkOutput("rwitm_mem", {31'd0, bus.mem_inst_q_alloc}, 32'd1);
        bus.ack_valid = 4'b0110;
        step();
        checkOutput("rwitm_wait", {31'd0, bus.resp_valid}, 32'd0);
        bus.ack_valid = 4'b1000;
        step();
        bus.ack_valid = 4'b0000;
        checkOutput("rwitm_wait2", {31'd0, bus.resp_valid}, 32'd0);
        step();
        checkOutput("rwitm_resp", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("rwitm_state", {24'd0, bus.resp_next_state}, 32'h02);

        $display("[TB] UPD with cache1 instr queue full for five cycles");
        bus.cache_inst_q_full = 4'b0010;
        applyStimulus(T_UPD, 3'd0, 3'd0, 8'h05);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("upd_stall", {28'd0, bus.cache_inst_q_alloc}, 32'd0);
        end
        bus.cache_inst_q_full = 4'b0000;
        step();
        checkOutput("upd_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'b0011);
        checkOutput("upd_op", {20'd0, bus.cache_inst_q_op}, 32'h02E);
        bus.ack_valid = 4'b0010;
        step();
        bus.ack_valid = 4'b0000;
        step();
        checkOutput("upd_resp", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("upd_state", {24'd0, bus.resp_next_state}, 32'h02);
        checkOutput("no_spurious_yet", {31'd0, bus.err_spurious_ack}, 32'd0);

        $display("[TB] RD with owner that never acks: timeout");
        applyStimulus(T_RD, 3'd0, 3'd0, 8'h08);
        step();
        repeat (7) step();
        checkOutput("tmo_not_yet", {31'd0, bus.err_timeout}, 32'd0);
        step();
        checkOutput("tmo_err", {31'd0, bus.err_timeout}, 32'd1);
        checkOutput("tmo_resp_early", {31'd0, bus.resp_valid}, 32'd0);
        step();
        checkOutput("tmo_resp", {31'd0, bus.resp_valid}, 32'd1);
        checkOutput("tmo_state", {24'd0, bus.resp_next_state}, 32'h05);

        $display("[TB] ack while idle");
        bus.ack_valid = 4'b0001;
        step();
        bus.ack_valid = 4'b0000;
        checkOutput("spurious_err", {31'd0, bus.err_spurious_ack}, 32'd1);

        $display("[TB] WR from modified cache0 and REPLY to cache2");
        applyStimulus(T_WR, 3'd0, 3'd0, 8'h02);
        step();
        checkOutput("wr_alloc", {31'd0, bus.mem_data_q_alloc}, 32'd1);
        checkOutput("wr_op", {29'd0, bus.mem_data_q_op}, 32'd4);
        step();
        checkOutput("wr_state", {24'd0, bus.resp_next_state}, 32'h01);
        applyStimulus(T_REPLY, 3'd0, 3'd2, 8'h41);
        step();
        checkOutput("reply_alloc", {28'd0, bus.cache_data_q_alloc}, 32'b0100);
        checkOutput("reply_op", {20'd0, bus.cache_data_q_op}, 32'h100);
        checkOutput("reply_mem", {31'd0, bus.mem_data_q_alloc}, 32'd0);
        step();
        checkOutput("reply_state", {24'd0, bus.resp_next_state}, 32'h41);

        $display("[TB] reset while waiting for an ack");
        applyStimulus(T_RD, 3'd0, 3'd0, 8'h08);
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("rstw_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("rstw_errs", {30'd0, bus.err_timeout, bus.err_spurious_ack}, 32'd0);
        checkOutput("rstw_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rstw_ready_after", {31'd0, bus.req_ready}, 32'd1);
        step();
        step();
        checkOutput("rstw_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        checkOutput("rstw_no_alloc", {28'd0, bus.cache_inst_q_alloc}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
